// File: rtl/register_file_pkg.sv
// Shared core constants: RoB sizing, architectural register count, decoded
// opcodes and RoB operation types used by the Decoder, RoB and register file.
package register_file_pkg;

   localparam int RoB_WIDTH = 3;
   localparam int REG_NUM   = 32;

   typedef enum logic [5:0] {
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XORR,
      OP_SRL, OP_SRA, OP_ORR, OP_ANDR
   } opcode_t;

   typedef enum logic [2:0] {
      OPT_REGISTER, OPT_BRANCH, OPT_JALR, OPT_STORE, OPT_EXIT
   } rob_op_t;

endpackage

// File: rtl/register_file_if.sv
// Rename / commit / operand-lookup bus between the dispatcher, RoB and the
// register file. No handshake: each *_en is a single-cycle command qualified by rdy_in.
interface register_file_if
   import register_file_pkg::*;
#(
   parameter int RoB_WIDTH = register_file_pkg::RoB_WIDTH
);

   logic                 rename_en;
   logic [4:0]           rename_rd;
   logic [RoB_WIDTH-1:0] rename_tag;

   logic                 commit_en;
   logic [4:0]           commit_rd;
   logic [RoB_WIDTH-1:0] commit_tag;
   logic [31:0]          commit_data;

   logic [4:0]           rs1_idx;
   logic [4:0]           rs2_idx;
   logic [31:0]          rs1_val;
   logic [31:0]          rs2_val;
   logic                 rs1_busy;
   logic                 rs2_busy;
   logic [RoB_WIDTH-1:0] rs1_tag;
   logic [RoB_WIDTH-1:0] rs2_tag;

   modport master (
      output rename_en, rename_rd, rename_tag,
      output commit_en, commit_rd, commit_tag, commit_data,
      output rs1_idx, rs2_idx,
      input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
   );

   modport slave (
      input  rename_en, rename_rd, rename_tag,
      input  commit_en, commit_rd, commit_tag, commit_data,
      input  rs1_idx, rs2_idx,
      output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
   );

endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register rename tracking (busy + RoB tag)
// and a same-cycle commit bypass on both operand lookup ports.
module register_file
   import register_file_pkg::*;
#(
   parameter int RoB_WIDTH = register_file_pkg::RoB_WIDTH,
   parameter int REG_NUM   = register_file_pkg::REG_NUM
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            flush_in,
   register_file_if.slave  bus
);

   localparam int LW = 32 + 1 + RoB_WIDTH;

   logic [31:0]          value_q [REG_NUM];
   logic                 busy_q  [REG_NUM];
   logic [RoB_WIDTH-1:0] tag_q   [REG_NUM];

   logic [REG_NUM-1:0] commit_sel;
   logic [REG_NUM-1:0] rename_sel;
   logic [LW-1:0]      rs1_word;
   logic [LW-1:0]      rs2_word;

   // x0 is never selected, so it keeps its reset value forever.
   always_comb begin
      commit_sel = '0;
      rename_sel = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         commit_sel[i] = bus.commit_en && (bus.commit_rd == 5'(i));
         rename_sel[i] = bus.rename_en && (bus.rename_rd == 5'(i));
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            busy_q[i]  <= 1'b0;
            tag_q[i]   <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (commit_sel[i]) begin
               value_q[i] <= bus.commit_data;
            end
            // Flush beats rename; rename beats the commit's busy clear.
            if (flush_in) begin
               busy_q[i] <= 1'b0;
            end else if (rename_sel[i]) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= bus.rename_tag;
            end else if (commit_sel[i] && busy_q[i] && (tag_q[i] == bus.commit_tag)) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // Returns {value, busy, tag}; a matching commit in flight is forwarded as not busy.
   function automatic logic [LW-1:0] lookup(input logic [4:0] idx);
      logic hit;
      hit = rdy_in && bus.commit_en && (idx != 5'd0) && (bus.commit_rd == idx)
            && busy_q[idx] && (tag_q[idx] == bus.commit_tag);
      if (hit) begin
         lookup = {bus.commit_data, 1'b0, {RoB_WIDTH{1'b0}}};
      end else if (busy_q[idx]) begin
         lookup = {value_q[idx], 1'b1, tag_q[idx]};
      end else begin
         lookup = {value_q[idx], 1'b0, {RoB_WIDTH{1'b0}}};
      end
   endfunction

   always_comb begin
      rs1_word = lookup(bus.rs1_idx);
      rs2_word = lookup(bus.rs2_idx);
   end

   assign {bus.rs1_val, bus.rs1_busy, bus.rs1_tag} = rs1_word;
   assign {bus.rs2_val, bus.rs2_busy, bus.rs2_tag} = rs2_word;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reference model of the register state,
// expected lookups queued at drive time and popped when outputs settle.
module tb_register_file;

   logic clk_in;
   logic rst_in;
   logic rdy_in;
   logic flush_in;

   register_file_if #(.RoB_WIDTH(3)) bus ();

   register_file #(.RoB_WIDTH(3), .REG_NUM(32)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus.slave)
   );

   // clock / reset
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // reference model
   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [2:0]  m_tag  [32];

   logic [35:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string name, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d",
                  name, got[35:4], got[3], got[2:0], exp[35:4], exp[3], exp[2:0]);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_val[i]  = 32'd0;
         m_busy[i] = 1'b0;
         m_tag[i]  = 3'd0;
      end
   endtask

   function automatic logic [35:0] exp_look(input logic [4:0] idx, input logic rdy,
                                            input logic cen, input logic [4:0] crd,
                                            input logic [2:0] ctag, input logic [31:0] cdata);
      if (idx == 5'd0) return 36'd0;
      if (rdy && cen && crd == idx && m_busy[idx] && m_tag[idx] == ctag)
         return {cdata, 1'b0, 3'd0};
      return {m_val[idx], m_busy[idx], m_busy[idx] ? m_tag[idx] : 3'd0};
   endfunction

   task automatic check_outputs(input string name);
      check_val({name, "_rs1"}, {bus.rs1_val, bus.rs1_busy, bus.rs1_tag}, exp_q.pop_front());
      check_val({name, "_rs2"}, {bus.rs2_val, bus.rs2_busy, bus.rs2_tag}, exp_q.pop_front());
   endtask

   // driver: one cycle of stimulus, expected lookups queued, model advanced at the edge
   task automatic step(input logic rdy, input logic fl,
                       input logic ren, input logic [4:0] rrd, input logic [2:0] rtag,
                       input logic cen, input logic [4:0] crd, input logic [2:0] ctag,
                       input logic [31:0] cdata, input logic [4:0] i1, input logic [4:0] i2,
                       input string name);
      logic clr;
      @(negedge clk_in);
      rdy_in          = rdy;
      flush_in        = fl;
      bus.rename_en   = ren;
      bus.rename_rd   = rrd;
      bus.rename_tag  = rtag;
      bus.commit_en   = cen;
      bus.commit_rd   = crd;
      bus.commit_tag  = ctag;
      bus.commit_data = cdata;
      bus.rs1_idx     = i1;
      bus.rs2_idx     = i2;
      exp_q.push_back(exp_look(i1, rdy, cen, crd, ctag, cdata));
      exp_q.push_back(exp_look(i2, rdy, cen, crd, ctag, cdata));
      #2;
      check_outputs(name);
      @(posedge clk_in);
      if (rdy) begin
         clr = 1'b0;
         if (cen && crd != 5'd0) begin
            m_val[crd] = cdata;
            clr = m_busy[crd] && (m_tag[crd] == ctag);
         end
         if (fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else begin
            if (clr) m_busy[crd] = 1'b0;
            if (ren && rrd != 5'd0) begin
               m_busy[rrd] = 1'b1;
               m_tag[rrd]  = rtag;
            end
         end
      end
   endtask

   task automatic idle(input logic [4:0] i1, input logic [4:0] i2, input string name);
      step(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'd0, i1, i2, name);
   endtask

   task automatic check_all_zero(input string name);
      for (int k = 0; k < 32; k += 4) begin
         bus.rs1_idx = 5'(k);
         bus.rs2_idx = 5'(31 - k);
         #1;
         exp_q.push_back(36'd0);
         exp_q.push_back(36'd0);
         check_outputs(name);
      end
   endtask

   // reset dropped asynchronously mid-cycle, with commands still on the bus
   task automatic async_reset();
      @(negedge clk_in);
      rdy_in          = 1'b1;
      bus.rename_en   = 1'b1;
      bus.rename_rd   = 5'd9;
      bus.rename_tag  = 3'd2;
      bus.commit_en   = 1'b1;
      bus.commit_rd   = 5'd5;
      bus.commit_tag  = m_tag[5];
      bus.commit_data = 32'hCAFE_0001;
      #2 rst_in = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_clear();
      @(posedge clk_in);
      check_all_zero("in_rst_edge");
      @(negedge clk_in);
      bus.rename_en = 1'b0;
      bus.commit_en = 1'b0;
      rst_in = 1'b1;
   endtask

   initial begin
      logic       r_rdy, r_fl, r_ren, r_cen;
      logic [4:0] r_rrd, r_crd, r_i1, r_i2;
      logic [2:0] r_rtag, r_ctag;

      rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
      bus.rename_en = 1'b0; bus.rename_rd = 5'd0; bus.rename_tag = 3'd0;
      bus.commit_en = 1'b0; bus.commit_rd = 5'd0; bus.commit_tag = 3'd0;
      bus.commit_data = 32'd0; bus.rs1_idx = 5'd0; bus.rs2_idx = 5'd0;
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      @(negedge clk_in);
      rst_in = 1'b1;

      // rename then commit with matching tag
      step(1, 0, 1, 5'd5, 3'd3, 0, 5'd0, 3'd0, 32'd0, 5'd5, 5'd0, "ren_x5");
      step(1, 0, 0, 5'd0, 3'd0, 1, 5'd5, 3'd3, 32'hDEADBEEF, 5'd5, 5'd5, "cmt_x5_byp");
      idle(5'd5, 5'd0, "x5_after_cmt");

      // stale commit must not clear a younger rename
      step(1, 0, 1, 5'd5, 3'd2, 0, 5'd0, 3'd0, 32'd0, 5'd5, 5'd0, "ren_x5_t2");
      step(1, 0, 1, 5'd5, 3'd4, 0, 5'd0, 3'd0, 32'd0, 5'd5, 5'd0, "ren_x5_t4");
      step(1, 0, 0, 5'd0, 3'd0, 1, 5'd5, 3'd2, 32'd7, 5'd5, 5'd0, "cmt_x5_stale");
      idle(5'd5, 5'd5, "x5_still_busy");

      // commit bypass on rs2
      step(1, 0, 1, 5'd6, 3'd1, 0, 5'd0, 3'd0, 32'd0, 5'd0, 5'd6, "ren_x6");
      step(1, 0, 0, 5'd0, 3'd0, 1, 5'd6, 3'd1, 32'h55, 5'd1, 5'd6, "cmt_x6_byp");
      idle(5'd6, 5'd6, "x6_after_cmt");

      // same-cycle commit and rename to one register: rename wins
      step(1, 0, 1, 5'd8, 3'd1, 0, 5'd0, 3'd0, 32'd0, 5'd8, 5'd0, "ren_x8");
      step(1, 0, 1, 5'd8, 3'd6, 1, 5'd8, 3'd1, 32'h11, 5'd8, 5'd8, "cmt_ren_x8");
      idle(5'd8, 5'd0, "x8_rename_wins");

      // flush with a same-cycle commit write; rename in that cycle ignored
      step(1, 0, 0, 5'd0, 3'd0, 1, 5'd2, 3'd0, 32'h22, 5'd0, 5'd0, "seed_x2");
      step(1, 0, 0, 5'd0, 3'd0, 1, 5'd3, 3'd0, 32'h33, 5'd0, 5'd0, "seed_x3");
      step(1, 0, 1, 5'd1, 3'd0, 0, 5'd0, 3'd0, 32'd0, 5'd1, 5'd0, "ren_x1");
      step(1, 0, 1, 5'd2, 3'd1, 0, 5'd0, 3'd0, 32'd0, 5'd2, 5'd1, "ren_x2");
      step(1, 0, 1, 5'd3, 3'd2, 0, 5'd0, 3'd0, 32'd0, 5'd3, 5'd2, "ren_x3");
      step(1, 1, 1, 5'd4, 3'd3, 1, 5'd1, 3'd0, 32'd9, 5'd1, 5'd4, "flush_cmt");
      idle(5'd1, 5'd2, "after_flush_a");
      idle(5'd3, 5'd4, "after_flush_b");
      idle(5'd5, 5'd8, "after_flush_c");

      // x0 is hard-wired
      step(1, 0, 1, 5'd0, 3'd5, 1, 5'd0, 3'd5, 32'hFFFFFFFF, 5'd0, 5'd0, "x0_write");
      idle(5'd0, 5'd0, "x0_after");

      // rdy_in low freezes rename, commit and flush
      step(1, 0, 1, 5'd10, 3'd3, 0, 5'd0, 3'd0, 32'd0, 5'd10, 5'd0, "ren_x10");
      step(0, 0, 1, 5'd7, 3'd6, 1, 5'd10, 3'd3, 32'hBAD, 5'd7, 5'd10, "rdy_low_a");
      step(0, 1, 0, 5'd0, 3'd0, 0, 5'd0, 3'd0, 32'd0, 5'd7, 5'd10, "rdy_low_flush");
      idle(5'd7, 5'd10, "after_rdy_low");

      // asynchronous reset mid-operation, then normal operation resumes
      async_reset();
      step(1, 0, 1, 5'd9, 3'd5, 1, 5'd9, 3'd0, 32'h99, 5'd9, 5'd5, "post_rst_first");
      idle(5'd9, 5'd5, "post_rst_second");

      // random traffic over a small register window to force collisions
      for (int n = 0; n < 400; n++) begin
         r_rdy  = ($urandom_range(0, 9) != 0);
         r_fl   = ($urandom_range(0, 24) == 0);
         r_ren  = ($urandom_range(0, 1) == 1);
         r_rrd  = 5'($urandom_range(0, 7));
         r_rtag = 3'($urandom_range(0, 7));
         r_cen  = ($urandom_range(0, 1) == 1);
         r_crd  = 5'($urandom_range(0, 7));
         r_ctag = ($urandom_range(0, 3) != 0) ? m_tag[r_crd] : 3'($urandom_range(0, 7));
         r_i1   = ($urandom_range(0, 1) == 1) ? r_crd : 5'($urandom_range(0, 7));
         r_i2   = 5'($urandom_range(0, 7));
         step(r_rdy, r_fl, r_ren, r_rrd, r_rtag, r_cen, r_crd, r_ctag,
              $urandom, r_i1, r_i2, "random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
